// File: rtl/wb_bypass_regfile.sv
// wb_bypass_regfile: pipeline register file with per-port operand latches that snoop writebacks, plus a busy scoreboard (optional X0_ZERO_EN hardwires x0)
module wb_bypass_regfile #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int RD_PORTS = 2,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                     p_clk,
  input  logic                     rst_n,
  input  logic                     stall,
  input  logic [RD_PORTS*AW-1:0]   raddr,
  input  logic [RD_PORTS-1:0]      ex_use,
  output logic [RD_PORTS*XLEN-1:0] ex_val,
  output logic [RD_PORTS*AW-1:0]   ex_src,
  output logic                     hazard,
  input  logic                     wb_valid,
  input  logic                     wb_kill,
  input  logic [AW-1:0]            wb_rd,
  input  logic [XLEN-1:0]          wb_data,
  input  logic                     iss_valid,
  input  logic [AW-1:0]            iss_rd,
  input  logic                     flush
);
  logic [XLEN-1:0]     r_regs [NREGS];
  logic [NREGS-1:0]    r_busy;
  logic [NREGS-1:0]    w_busy_nxt;
  logic [RD_PORTS-1:0] w_hz;
  logic                w_wr_act;
  logic                w_iss_act;
`ifdef X0_ZERO_EN
  assign w_wr_act  = wb_valid & ~wb_kill & (wb_rd != '0);
  assign w_iss_act = iss_valid & (iss_rd != '0);
`else
  assign w_wr_act  = wb_valid & ~wb_kill;
  assign w_iss_act = iss_valid;
`endif
  // architectural register array, written on an active writeback
  always_ff @(posedge p_clk or negedge rst_n)
    if (!rst_n)
      for (int k = 0; k < NREGS; k++) r_regs[k] <= '0;
    else if (w_wr_act)
      r_regs[wb_rd] <= wb_data;
  // issue sets, any writeback (killed too) clears, set wins, flush clears all
  always_comb
    w_busy_nxt = flush ? '0
               : (r_busy & ~(wb_valid ? NREGS'(1) << wb_rd : '0))
               | (w_iss_act ? NREGS'(1) << iss_rd : '0);
  // scoreboard state
  always_ff @(posedge p_clk or negedge rst_n)
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  for (genvar g = 0; g < RD_PORTS; g++) begin : g_port
    logic [AW-1:0]   w_raddr;
    logic [AW-1:0]   r_src;
    logic [XLEN-1:0] r_opnd;
    logic            w_hit;
    assign w_raddr = raddr[g*AW +: AW];
    assign w_hit   = w_wr_act & (wb_rd == r_src);
    // capture on a free cycle (write-first), otherwise hold and snoop writebacks
    always_ff @(posedge p_clk or negedge rst_n)
      if (!rst_n) begin
        r_src  <= '0;
        r_opnd <= '0;
      end else if (!stall) begin
        r_src  <= w_raddr;
        r_opnd <= (w_wr_act & (wb_rd == w_raddr)) ? wb_data : r_regs[w_raddr];
      end else if (w_hit) begin
        r_opnd <= wb_data;
      end
    assign ex_val[g*XLEN +: XLEN] = w_hit ? wb_data : r_opnd;
    assign ex_src[g*AW +: AW]     = r_src;
    assign w_hz[g]                = ex_use[g] & r_busy[r_src] & ~w_hit;
  end
  assign hazard = |w_hz;
endmodule
